// File: rtl/prog_loader.sv
// Boot-time program loader: packs a valid/ready byte stream (MSB first) into
// 24-bit words, writes them to instruction memory at sequential addresses and
// then releases the CPU. Partial final words and overlong streams latch
// sticky error flags that only reset clears.
module prog_loader #(
    parameter int unsigned WORD_W = 24,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic              err_partial,
    output logic              err_overflow
);

    typedef enum logic [2:0] {
        StLoad,
        StDoneWr,
        StOvfWr,
        StRun,
        StError
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-9:0]   shift_q, shift_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_partial_q, err_partial_d;
    logic                err_overflow_q, err_overflow_d;
    logic                accept;

    assign in_ready     = (state_q == StLoad);
    assign cpu_run      = (state_q == StRun);
    assign accept       = in_valid && in_ready;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign word_count   = count_q;
    assign err_partial  = err_partial_q;
    assign err_overflow = err_overflow_q;

    // Next-state: byte assembly, write strobe, address advance and state transitions.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shift_d        = shift_q;
        we_d           = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        count_d        = count_q;
        err_partial_d  = err_partial_q;
        err_overflow_d = err_overflow_q;

        // Address and count advance the cycle after the write pulse.
        if (we_q) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
        end

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (idx_q != 2'd2) begin
                        shift_d = {shift_q[WORD_W-17:0], in_data};
                        idx_d   = idx_q + 1'b1;
                        if (in_last) begin
                            state_d       = StError;
                            err_partial_d = 1'b1;
                        end
                    end else begin
                        idx_d   = 2'd0;
                        we_d    = 1'b1;
                        wdata_d = {shift_q, in_data};
                        if (in_last) begin
                            state_d = StDoneWr;
                        end else if (addr_q == LastAddr) begin
                            state_d = StOvfWr;
                        end
                    end
                end
            end
            StDoneWr: state_d = StRun;
            StOvfWr: begin
                state_d        = StError;
                err_overflow_d = 1'b1;
            end
            StRun: begin
                if (reload) begin
                    state_d = StLoad;
                    addr_d  = '0;
                    count_d = '0;
                    idx_d   = 2'd0;
                end
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StLoad;
            idx_q          <= 2'd0;
            shift_q        <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            count_q        <= '0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shift_q        <= shift_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            count_q        <= count_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (DEPTH=4 so overflow is reachable).
module tb_prog_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORD_W = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   word_count;
    logic              err_partial;
    logic              err_overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W+WORD_W-1:0] exp_q[$];

    prog_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .reload      (reload),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_run     (cpu_run),
        .word_count  (word_count),
        .err_partial (err_partial),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                logic [ADDR_W+WORD_W-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_wdata, e[ADDR_W+WORD_W-1:WORD_W], e[WORD_W-1:0]);
                end
            end
        end
    end

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
    endtask

    // Drops in_valid and waits (bounded) for the write strobe; leaves us on that negedge.
    task automatic wait_we(input string name);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (mem_we === 1'b1) begin
                found = 1;
                break;
            end
        end
        check({name, "_we_seen"}, 32'(found), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        // Reset sequence 0 -> 1 -> 0 -> 1.
        rst_n = 1'b0;
        #10 rst_n = 1'b1;
        #10 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        idle(2);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_errs", 32'({err_partial, err_overflow}), 32'd0);

        // Two-word load, back-to-back bytes.
        expect_write(8'd0, 24'hE00001);
        expect_write(8'd1, 24'h123456);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        wait_we("load2");
        check("load2_run_during_we", 32'(cpu_run), 32'd0);
        @(negedge clk);
        check("load2_cpu_run", 32'(cpu_run), 32'd1);
        check("load2_in_ready", 32'(in_ready), 32'd0);
        check("load2_word_count", 32'(word_count), 32'd2);
        check("load2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reload from RUN and load one word.
        pulse_reload();
        check("reload_cpu_run", 32'(cpu_run), 32'd0);
        check("reload_in_ready", 32'(in_ready), 32'd1);
        check("reload_addr", 32'(mem_addr), 32'd0);
        check("reload_count", 32'(word_count), 32'd0);
        expect_write(8'd0, 24'h000007);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h07, 1'b1);
        wait_we("reload");
        @(negedge clk);
        check("reload_cpu_run_again", 32'(cpu_run), 32'd1);
        check("reload_word_count", 32'(word_count), 32'd1);

        // Reset mid-way through the second word.
        pulse_reset();
        expect_write(8'd0, 24'h111111);
        send_byte(8'h11, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle(1);
        check("midrst_addr_before", 32'(mem_addr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_count", 32'(word_count), 32'd0);
        check("midrst_wdata", 32'(mem_wdata), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        expect_write(8'd0, 24'hABCDEF);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'hEF, 1'b1);
        wait_we("fresh");
        @(negedge clk);
        check("fresh_cpu_run", 32'(cpu_run), 32'd1);
        check("fresh_count", 32'(word_count), 32'd1);

        // Partial word: error, reload ignored, reset clears.
        pulse_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        idle(3);
        check("partial_err", 32'(err_partial), 32'd1);
        check("partial_in_ready", 32'(in_ready), 32'd0);
        check("partial_cpu_run", 32'(cpu_run), 32'd0);
        check("partial_count", 32'(word_count), 32'd0);
        pulse_reload();
        idle(2);
        check("partial_reload_ignored", 32'({err_partial, in_ready, cpu_run}), 32'b100);
        pulse_reset();
        idle(1);
        check("partial_cleared", 32'({err_partial, in_ready}), 32'b01);

        // Overflow with DEPTH=4: five words offered, none last.
        expect_write(8'd0, 24'h010203);
        expect_write(8'd1, 24'h040506);
        expect_write(8'd2, 24'h070809);
        expect_write(8'd3, 24'h0A0B0C);
        for (int i = 1; i <= 15; i++) begin
            send_byte(8'(i), 1'b0);
        end
        idle(4);
        check("ovf_err", 32'(err_overflow), 32'd1);
        check("ovf_partial", 32'(err_partial), 32'd0);
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        check("ovf_cpu_run", 32'(cpu_run), 32'd0);
        check("ovf_count", 32'(word_count), 32'd4);
        check("ovf_queue_drained", 32'(exp_q.size()), 32'd0);
        pulse_reload();
        idle(2);
        check("ovf_sticky", 32'({err_overflow, in_ready}), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
